// File: rtl/jtcop_romrsp_pkg.sv
// Shared types and constants for the jtcop graphics ROM responder.
// Optional statistics counters are enabled with JTCOP_ROMRSP_STATS_EN.
package jtcop_romrsp_pkg;

    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int NSLOT = 4;

    localparam logic [1:0] SLOT_BA0 = 2'd0;
    localparam logic [1:0] SLOT_BA1 = 2'd1;
    localparam logic [1:0] SLOT_BA2 = 2'd2;
    localparam logic [1:0] SLOT_OBJ = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Returns {found, slot}: first pending slot scanning upward from rr.
    function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] rr);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = rr + 2'(i);
            if (pend[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/jtcop_romrsp_slot.sv
// One-entry cache for a single requester: tag/valid/word plus registered hit flag.
module jtcop_romrsp_slot
    import jtcop_romrsp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          clr_valid,
    input  logic          wr_lo,
    input  logic          wr_hi,
    input  logic [15:0]   din,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] word
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [DW-1:0] word_q;
    logic          ok_q;

    assign hit  = valid_q & (tag_q == addr);
    assign ok   = ok_q;
    assign word = word_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            // A fill in progress drops valid so a half-written word never matches.
            if (fill) begin
                valid_q <= 1'b1;
                tag_q   <= fill_tag;
            end else if (clr_valid) begin
                valid_q <= 1'b0;
            end
            if (wr_lo) word_q[15:0]  <= din;
            if (wr_hi) word_q[31:16] <= din;
            ok_q <= cs & hit;
        end
    end

endmodule

// File: rtl/jtcop_romrsp.sv
// Four-slot graphics ROM responder sharing one 16-bit SDRAM burst port.
// Define JTCOP_ROMRSP_STATS_EN for per-slot hit/miss counters on st_dout.
module jtcop_romrsp
    import jtcop_romrsp_pkg::*;
#(
    parameter int              SDAW    = 22,
    parameter logic [SDAW-1:0] OFFSET0 = '0,
    parameter logic [SDAW-1:0] OFFSET1 = '0,
    parameter logic [SDAW-1:0] OFFSET2 = '0,
    parameter logic [SDAW-1:0] OFFSET3 = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        slot_cs,
    input  logic [71:0]       slot_addr,
    output logic [127:0]      slot_data,
    output logic [3:0]        slot_ok,
    output logic              sdram_req,
    output logic [SDAW-1:0]   sdram_addr,
    input  logic              sdram_ack,
    input  logic              sdram_dst,
    input  logic [15:0]       sdram_din,
    input  logic              sdram_rdy,
    input  logic [7:0]        st_addr,
    output logic [7:0]        st_dout
);

    state_t          state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [AW-1:0]   tag_q, tag_d;
    logic [1:0]      rr_q, rr_d;
    logic            req_q, req_d;
    logic [SDAW-1:0] sa_q, sa_d;
    logic [1:0]      dcnt_q, dcnt_d;

    logic [AW-1:0]   addr_a [NSLOT];
    logic [SDAW-1:0] offs   [NSLOT];
    logic [3:0]      hit, pend;
    logic [2:0]      pick;
    logic            take, wr_lo, wr_hi, fill, issue;

    assign offs[0] = OFFSET0;
    assign offs[1] = OFFSET1;
    assign offs[2] = OFFSET2;
    assign offs[3] = OFFSET3;

    assign take = (state_q == ST_DATA) | ((state_q == ST_REQ) & sdram_ack);
    assign pick = rr_pick(pend, rr_q);

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic target;
            assign target       = (slot_q == 2'(gi)) & (state_q != ST_IDLE);
            assign addr_a[gi]   = slot_addr[AW*gi +: AW];
            assign pend[gi]     = slot_cs[gi] & ~hit[gi] & ~target;

            jtcop_romrsp_slot u_slot (
                .clk       (clk),
                .rst       (rst),
                .cs        (slot_cs[gi]),
                .addr      (addr_a[gi]),
                .clr_valid (target & take),
                .wr_lo     (target & wr_lo),
                .wr_hi     (target & wr_hi),
                .din       (sdram_din),
                .fill      (target & fill),
                .fill_tag  (tag_q),
                .hit       (hit[gi]),
                .ok        (slot_ok[gi]),
                .word      (slot_data[DW*gi +: DW])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        tag_d   = tag_q;
        rr_d    = rr_q;
        req_d   = req_q;
        sa_d    = sa_q;
        dcnt_d  = dcnt_q;
        wr_lo   = 1'b0;
        wr_hi   = 1'b0;
        fill    = 1'b0;
        issue   = 1'b0;
        // Only the first two strobes of a burst land in the word.
        if (take && sdram_dst && dcnt_q < 2'd2) begin
            wr_lo  = (dcnt_q == 2'd0);
            wr_hi  = (dcnt_q == 2'd1);
            dcnt_d = dcnt_q + 2'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    slot_d  = pick[1:0];
                    tag_d   = addr_a[pick[1:0]];
                    sa_d    = offs[pick[1:0]] + SDAW'({addr_a[pick[1:0]], 1'b0});
                    req_d   = 1'b1;
                    dcnt_d  = 2'd0;
                    issue   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sdram_rdy) begin
                    fill    = 1'b1;
                    rr_d    = slot_q + 2'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            slot_q  <= 2'd0;
            tag_q   <= '0;
            rr_q    <= 2'd0;
            req_q   <= 1'b0;
            sa_q    <= '0;
            dcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            tag_q   <= tag_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
            sa_q    <= sa_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = sa_q;

`ifdef JTCOP_ROMRSP_STATS_EN
    logic [7:0] miss_q [NSLOT];
    logic [7:0] hitc_q [NSLOT];
    logic [3:0] ok_prev_q;
    logic [7:0] st_q;
    logic       unused_st;

    assign unused_st = ^st_addr[7:3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                miss_q[i] <= 8'd0;
                hitc_q[i] <= 8'd0;
            end
            ok_prev_q <= 4'd0;
            st_q      <= 8'hff;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (issue && slot_d == 2'(i) && miss_q[i] != 8'hff)
                    miss_q[i] <= miss_q[i] + 8'd1;
                if (slot_ok[i] && !ok_prev_q[i] && hitc_q[i] != 8'hff)
                    hitc_q[i] <= hitc_q[i] + 8'd1;
            end
            ok_prev_q <= slot_ok;
            st_q      <= st_addr[2] ? hitc_q[st_addr[1:0]] : miss_q[st_addr[1:0]];
        end
    end

    assign st_dout = st_q;
`else
    logic unused_st;
    assign unused_st = ^{st_addr, issue};
    assign st_dout   = 8'hff;
`endif

endmodule

// File: tb/tb_jtcop_romrsp.sv
// Directed bench for jtcop_romrsp: acts as SDRAM controller and checks each step.
module tb_jtcop_romrsp;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   slot_cs;
    logic [71:0]  slot_addr;
    logic [127:0] slot_data;
    logic [3:0]   slot_ok;
    logic         sdram_req;
    logic [21:0]  sdram_addr;
    logic         sdram_ack, sdram_dst, sdram_rdy;
    logic [15:0]  sdram_din;
    logic [7:0]   st_addr, st_dout;

    int n_vec = 0;
    int n_err = 0;
    logic [21:0] seen;

    always #5 clk = ~clk;

    jtcop_romrsp #(
        .SDAW(22), .OFFSET0(22'h0), .OFFSET1(22'h10000),
        .OFFSET2(22'h20000), .OFFSET3(22'h30000)
    ) dut (
        .clk(clk), .rst(rst), .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_data(slot_data), .slot_ok(slot_ok), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
        .sdram_din(sdram_din), .sdram_rdy(sdram_rdy), .st_addr(st_addr),
        .st_dout(st_dout)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic set_addr(input int n, input logic [17:0] a);
        slot_addr[18*n +: 18] = a;
    endtask

    task automatic wait_req(output logic [21:0] a);
        int n;
        n = 0;
        while (!sdram_req && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 128'(sdram_req), 128'd1);
        a = sdram_addr;
    endtask

    task automatic do_ack();
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
    endtask

    task automatic do_dst(input logic [15:0] d);
        sdram_dst = 1'b1;
        sdram_din = d;
        @(negedge clk);
        sdram_dst = 1'b0;
    endtask

    task automatic do_rdy();
        sdram_rdy = 1'b1;
        @(negedge clk);
        sdram_rdy = 1'b0;
    endtask

    task automatic burst(input logic [15:0] lo, input logic [15:0] hi);
        do_ack();
        do_dst(lo);
        do_dst(hi);
        do_rdy();
    endtask

    initial begin
        int cnt;
        rst = 1'b0; slot_cs = 4'd0; slot_addr = '0;
        sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
        st_addr = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_ok",    128'(slot_ok),    128'd0);
        check("rst_data",  slot_data,        128'd0);
        check("rst_req",   128'(sdram_req),  128'd0);
        check("rst_addr",  128'(sdram_addr), 128'd0);
        check("rst_st",    128'(st_dout),    128'hff);
        rst = 1'b1;
        @(negedge clk);

        // Cold miss on slot 1
        slot_cs[1] = 1'b1; set_addr(1, 18'h00005);
        @(negedge clk);
        check("cold_req_lat", 128'(sdram_req), 128'd1);
        wait_req(seen);
        check("cold_addr", 128'(seen), 128'h1000A);
        burst(16'h1234, 16'hABCD);
        check("cold_data", 128'(slot_data[63:32]), 128'hABCD1234);
        check("cold_ok_1", 128'(slot_ok[1]), 128'd0);
        @(negedge clk);
        check("cold_ok_2", 128'(slot_ok[1]), 128'd1);

        // Hit after a toggle that is never fetched (FSM busy on slot 0)
        slot_cs[0] = 1'b1; set_addr(0, 18'h00010);
        @(negedge clk);
        wait_req(seen);
        check("s0_addr", 128'(seen), 128'h20);
        set_addr(1, 18'h00006);
        @(negedge clk);
        check("toggle_ok", 128'(slot_ok[1]), 128'd0);
        set_addr(1, 18'h00005);
        @(negedge clk);
        check("hit_ok", 128'(slot_ok[1]), 128'd1);
        burst(16'h5678, 16'h9ABC);
        check("s0_data", 128'(slot_data[31:0]), 128'h9ABC5678);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (sdram_req) cnt++;
        end
        check("hit_no_req", 128'(cnt), 128'd0);

        // Round-robin: four simultaneous misses from rr=0
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        slot_cs = 4'hf;
        set_addr(0, 18'h011); set_addr(1, 18'h022);
        set_addr(2, 18'h033); set_addr(3, 18'h044);
        wait_req(seen); check("rr1_0", 128'(seen), 128'h00022);
        burst(16'h0A00, 16'h0B00);
        wait_req(seen); check("rr1_1", 128'(seen), 128'h10044);
        burst(16'h0A01, 16'h0B01);
        wait_req(seen); check("rr1_2", 128'(seen), 128'h20066);
        burst(16'h0A02, 16'h0B02);
        wait_req(seen); check("rr1_3", 128'(seen), 128'h30088);
        burst(16'h0A03, 16'h0B03);
        check("rr1_data", slot_data,
              {32'h0B030A03, 32'h0B020A02, 32'h0B010A01, 32'h0B000A00});
        set_addr(1, 18'h023);
        wait_req(seen); check("rr2_1", 128'(seen), 128'h10046);
        set_addr(0, 18'h012); set_addr(3, 18'h045);
        burst(16'h1A01, 16'h1B01);
        wait_req(seen); check("rr2_3", 128'(seen), 128'h3008A);
        burst(16'h1A03, 16'h1B03);
        wait_req(seen); check("rr2_0", 128'(seen), 128'h00024);
        burst(16'h1A00, 16'h1B00);

        // Address change mid-fetch on slot 0
        slot_cs = 4'b0001; set_addr(0, 18'h100);
        @(negedge clk);
        wait_req(seen); check("mid_addr1", 128'(seen), 128'h200);
        do_ack();
        do_dst(16'h1111);
        set_addr(0, 18'h200);
        do_dst(16'h2222);
        do_rdy();
        check("mid_ok_a", 128'(slot_ok[0]), 128'd0);
        @(negedge clk);
        check("mid_ok_b", 128'(slot_ok[0]), 128'd0);
        wait_req(seen); check("mid_addr2", 128'(seen), 128'h400);
        burst(16'h3333, 16'h4444);
        check("mid_ok_c", 128'(slot_ok[0]), 128'd0);
        @(negedge clk);
        check("mid_ok_d", 128'(slot_ok[0]), 128'd1);
        check("mid_data", 128'(slot_data[31:0]), 128'h44443333);

        // Reset between the two data strobes
        slot_cs = 4'b0100; set_addr(2, 18'h055);
        @(negedge clk);
        wait_req(seen); check("rb_addr", 128'(seen), 128'h200AA);
        do_ack();
        do_dst(16'hAAAA);
        slot_cs = 4'd0;
        rst = 1'b0;
        #1;
        check("rb_ok",   128'(slot_ok),    128'd0);
        check("rb_data", slot_data,        128'd0);
        check("rb_req",  128'(sdram_req),  128'd0);
        check("rb_addr0", 128'(sdram_addr), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        do_dst(16'h5555);
        do_rdy();
        check("rb_late_data", slot_data,       128'd0);
        check("rb_late_ok",   128'(slot_ok),   128'd0);
        check("rb_late_req",  128'(sdram_req), 128'd0);
        slot_cs = 4'b0101; set_addr(0, 18'h200);
        wait_req(seen); check("rb_restart0", 128'(seen), 128'h400);
        burst(16'h0101, 16'h0202);
        wait_req(seen); check("rb_then2", 128'(seen), 128'h200AA);
        burst(16'h0303, 16'h0404);

`ifdef JTCOP_ROMRSP_STATS_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        slot_cs = 4'b0100;
        for (int i = 0; i < 300; i++) begin
            set_addr(2, (i % 2 == 0) ? 18'h100 : 18'h101);
            wait_req(seen);
            burst(16'(i), 16'(i));
        end
        st_addr = 8'd2;
        repeat (2) @(negedge clk);
        check("st_miss2_sat", 128'(st_dout), 128'hff);
        st_addr = 8'd1;
        repeat (2) @(negedge clk);
        check("st_miss1", 128'(st_dout), 128'd0);
`else
        st_addr = 8'd2;
        repeat (2) @(negedge clk);
        check("st_fixed", 128'(st_dout), 128'hff);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtcop_romrsp.md
# jtcop_romrsp

Responder side of the graphics ROM request interface (`cs`/`addr` → `data`/`ok`) issued by the three BAC06 tile layers and the object engine. Serves four requesters from one 16-bit SDRAM burst port. Each slot holds a one-entry cache: repeat addresses complete without SDRAM traffic, and misses are arbitrated round-robin. Sits between the video top and the SDRAM controller.

## Interface
Parameters:
- `SDAW`, 22: SDRAM word-address width.
- `OFFSET0`..`OFFSET3`, 0: per-slot SDRAM base, in 16-bit words.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `slot_cs` in 4: request enable per slot. Slot 0=BA0, 1=BA1, 2=BA2, 3=object.
- `slot_addr` in 72: four packed 18-bit 32-bit-word addresses. Slot n uses bits [18n+17:18n].
- `slot_data` out 128: four packed 32-bit words.
- `slot_ok` out 4: data valid for the current address.
- `sdram_req` out 1: burst request.
- `sdram_addr` out SDAW: word address of the burst.
- `sdram_ack` in 1: request accepted, one-cycle pulse.
- `sdram_dst` in 1: data strobe; `sdram_din` is valid in that cycle.
- `sdram_din` in 16: read data.
- `sdram_rdy` in 1: burst complete, one-cycle pulse.
- `st_addr` in 8: status select.
- `st_dout` out 8: status data.

## Operation
- Per-slot state: `valid`, `tag[17:0]`, `word[31:0]`. Reset clears `valid` to 0, `tag` to 0 and `word` to 0.
- Hit: `slot_ok[n]` is registered as `slot_cs[n] & valid[n] & tag[n]==addr[n]`. `slot_data[n]` is `word[n]` at all times.
- Miss: the slot is pending when `cs` is high and there is no hit, and the slot is not currently being fetched.
- FSM states:
  - IDLE: pick the first pending slot starting from the round-robin pointer `rr`. Latch the slot id and address, set `sdram_addr` = OFFSETn + {addr,1'b0}, assert `sdram_req`, go to REQ. If nothing is pending, stay in IDLE.
  - REQ: hold `sdram_req` and `sdram_addr` until `sdram_ack`. Then drop `sdram_req` and go to DATA.
  - DATA: the first `sdram_dst` is stored in `word[15:0]` and the second in `word[31:16]`. Extra strobes are ignored. On `sdram_rdy`, write the latched address to `tag` and set `valid`, set `rr` = slot+1 mod 4, and return to IDLE.
- Address change mid-fetch: the fetched word is still written under the latched tag. `ok` stays low because the tag no longer matches. In the following IDLE, the slot becomes pending again for the new address.
- `cs` low mid-fetch: the fetch completes and fills the cache. `ok` stays low.
- During a fill, `valid[n]` is cleared in the DATA state, so a stale `word` is never flagged with a matching `tag`.
- Address arithmetic: SDRAM address is an unsigned SDAW-bit sum, and wrap-around is silent.
- Reset asserted mid-burst:
  - All state clears immediately and the FSM goes to IDLE.
  - `sdram_req` is 0.
  - Any later `dst`/`rdy` pulses from the aborted burst are ignored.
- Reset values: `slot_ok`=0, `slot_data`=0, `sdram_req`=0, `sdram_addr`=0, `st_dout`=0xff, `rr`=0, FSM=IDLE.

## Timing
- Hit latency: `slot_ok` rises one `clk` after `cs`/`addr` settle on a cached address.
- Miss latency, with the FSM idle:
  - `sdram_req` rises 1 cycle after the miss is seen.
  - `slot_ok` rises 2 cycles after `sdram_rdy`: one for the cache write, one for the registered compare.
- The FSM issues no new request in the `sdram_rdy` cycle. The next request starts at the earliest on the following cycle.
- Simultaneous misses are served in rr order. Worst-case wait for a slot is three other bursts.
- A `sdram_ack` and a `sdram_dst` in the same cycle are both honoured: the FSM moves to DATA and stores the word.

## Configuration
- `JTCOP_ROMRSP_STATS_EN` defined:
  - Each slot has an 8-bit saturating miss counter (bursts issued) and an 8-bit saturating hit counter (rising edges of `ok`).
  - `st_addr[2:0]` selects: 0-3 miss slot 0-3, 4-7 hit slot 0-3.
  - `st_dout` is registered. Counters clear on reset.
- Undefined: no counters, and `st_dout` is fixed at 0xff.

## Structure
- Shared package `jtcop_romrsp_pkg`:
  - FSM state encoding (IDLE=0, REQ=1, DATA=2).
  - Slot index constants SLOT_BA0..SLOT_OBJ.
  - Packed-bus slice widths (AW=18, DW=32).
- Sub-module `jtcop_romrsp_slot`: holds one slot's tag/valid/word and its hit compare. It is instantiated four times. The arbiter and FSM stay in the top.

## Test plan
- Cold miss:
  - Stimulus: OFFSET1=0x10000, slot 1 cs=1, addr=0x00005. SDRAM returns 0x1234 then 0xABCD.
  - Required: `sdram_addr`=0x1000A, `slot_data[63:32]`=0xABCD1234, `slot_ok[1]` high 2 cycles after `rdy`.
- Hit:
  - Stimulus: repeat slot 1 addr 0x00005 after one toggle to 0x00006 and back, with 0x00006 never completed.
  - Required: 0x00005 returns `ok` in 1 cycle with no `sdram_req`.
- Round-robin:
  - Stimulus: all four slots miss together with rr=0.
  - Required: bursts are issued in order 0,1,2,3. After the second round, with slots 0 and 3 pending and rr=2, order is 3 then 0.
- Address change mid-fetch:
  - Stimulus: slot 0 changes addr 0x100 → 0x200 during DATA.
  - Required: `ok` stays low, a second burst is issued for 0x200, and `ok` rises only for 0x200.
- Reset mid-burst:
  - Stimulus: `rst`=0 between the two `dst` strobes, then the late `rdy` arrives.
  - Required: all outputs 0, `valid` cleared, the late `rdy` is ignored, and the next request restarts from slot 0.
- Stats (with `JTCOP_ROMRSP_STATS_EN`):
  - Stimulus: 300 misses on slot 2, then `st_addr`=2.
  - Required: `st_dout`=0xFF (saturated). Without the macro, `st_dout`=0xFF at all times.
